// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF    = 8;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_burst_counter.sv
// Saturating count of consecutive grants held by the current owner.
module mem_arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_at_limit
);

    localparam logic [CW-1:0] LIMIT    = CW'(MAX_BURST);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(MAX_BURST - 1);

    logic [CW-1:0] r_count;

    // Count register: clear wins over increment, holds at LIMIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // High when a grant taken now makes (or keeps) the burst at its limit.
    assign o_at_limit = (r_count == LIMIT_M1) || (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for one synchronous-read memory port with a burst limit.
// Build option MEM_ARB_RR_EN: round-robin IDLE tie-break instead of port-0 priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_write,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_write,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_to_memory,
    output logic              mem_write,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_from_memory
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              r_last_owner;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_cnt_clear;
    logic              w_cnt_inc;
    logic              w_at_limit;
    logic              w_tie1;

`ifdef MEM_ARB_RR_EN
    assign w_tie1 = (r_last_owner == PORT0);
`else
    assign w_tie1 = 1'b0;
`endif

    mem_arb_burst_counter #(
        .MAX_BURST (MAX_BURST)
    ) u_burst (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_clear    (w_cnt_clear),
        .i_inc      (w_cnt_inc),
        .o_at_limit (w_at_limit)
    );

    // Next-state, grant and burst-counter control.
    always_comb begin
        w_next      = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_cnt_clear = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clear = 1'b1;
                if (m0_req && m1_req) begin
                    w_next = w_tie1 ? ST_OWN1 : ST_OWN0;
                end else if (m0_req) begin
                    w_next = ST_OWN0;
                end else if (m1_req) begin
                    w_next = ST_OWN1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (m0_req) begin
                    w_gnt0    = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (m1_req && w_at_limit) begin
                        w_next      = ST_OWN1;
                        w_cnt_clear = 1'b1;
                    end else begin
                        w_next = ST_OWN0;
                    end
                end else begin
                    w_cnt_clear = 1'b1;
                    w_next      = m1_req ? ST_OWN1 : ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (m1_req) begin
                    w_gnt1    = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (m0_req && w_at_limit) begin
                        w_next      = ST_OWN0;
                        w_cnt_clear = 1'b1;
                    end else begin
                        w_next = ST_OWN1;
                    end
                end else begin
                    w_cnt_clear = 1'b1;
                    w_next      = m0_req ? ST_OWN0 : ST_IDLE;
                end
            end
            default: begin
                w_cnt_clear = 1'b1;
                w_next      = ST_IDLE;
            end
        endcase
    end

    // Memory port mux; everything parks at zero when nobody is granted.
    always_comb begin
        mem_en        = w_gnt0 | w_gnt1;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_to_memory = '0;
        if (w_gnt0) begin
            mem_write     = m0_write;
            mem_address   = m0_addr;
            mem_to_memory = m0_wdata;
        end else if (w_gnt1) begin
            mem_write     = m1_write;
            mem_address   = m1_addr;
            mem_to_memory = m1_wdata;
        end else begin
            mem_write     = 1'b0;
        end
    end

    // State, owner history and read-return registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_last_owner <= PORT1;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
        end else begin
            r_state   <= w_next;
            r_rvalid0 <= w_gnt0 & ~m0_write;
            r_rvalid1 <= w_gnt1 & ~m1_write;
            if (w_gnt0) begin
                r_last_owner <= PORT0;
            end else if (w_gnt1) begin
                r_last_owner <= PORT1;
            end
            if (r_rvalid0) begin
                r_rdata0 <= mem_from_memory;
            end
            if (r_rvalid1) begin
                r_rdata1 <= mem_from_memory;
            end
        end
    end

    // Read data is live from memory in the rvalid cycle, then held.
    assign m0_rdata  = r_rvalid0 ? mem_from_memory : r_rdata0;
    assign m1_rdata  = r_rvalid1 ? mem_from_memory : r_rdata1;
    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural synchronous memory.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       m0_req, m0_write, m0_gnt, m0_rvalid;
    logic [7:0] m0_addr, m0_wdata, m0_rdata;
    logic       m1_req, m1_write, m1_gnt, m1_rvalid;
    logic [7:0] m1_addr, m1_wdata, m1_rdata;
    logic [7:0] mem_address, mem_to_memory, mem_from_memory;
    logic       mem_write, mem_en;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] tb_mem [0:255];
    bit         written [0:255];

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_to_memory(mem_to_memory),
        .mem_write(mem_write), .mem_en(mem_en), .mem_from_memory(mem_from_memory)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] seed(input logic [7:0] a);
        case (a)
            8'h10:   seed = 8'hAA;
            8'h30:   seed = 8'h11;
            8'h31:   seed = 8'h22;
            default: seed = a ^ 8'h5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                tb_mem[mem_address]  <= mem_to_memory;
                written[mem_address] <= 1'b1;
            end else begin
                mem_from_memory <= written[mem_address] ? tb_mem[mem_address] : seed(mem_address);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_write} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_en, mem_write});
        end
        n_checks++;
        if ({m0_rdata, m1_rdata, mem_address, mem_to_memory} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00000000",
                     {m0_rdata, m1_rdata, mem_address, mem_to_memory});
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (mem_en !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_mem_en: got %b expected 0", mem_en);
            end
        end
    endtask

    task automatic test_read();
        tick();
        m0_req = 1'b1; m0_addr = 8'h10; m0_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL read_latency: m0_gnt got %b expected 0", m0_gnt);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, mem_en, mem_write, mem_address} !== {3'b110, 8'h10}) begin
            n_fail++;
            $display("FAIL read_grant: got %b_%h expected 110_10",
                     {m0_gnt, mem_en, mem_write}, mem_address);
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_rvalid, m0_rdata} !== {2'b10, 8'hAA}) begin
            n_fail++;
            $display("FAIL read_return: got %b_%h expected 10_aa", {m0_rvalid, m1_rvalid}, m0_rdata);
        end
        tick(); tick();
    endtask

    task automatic test_write();
        tick();
        m1_req = 1'b1; m1_addr = 8'h20; m1_wdata = 8'h55; m1_write = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if ({m1_gnt, m0_gnt, mem_write, mem_address, mem_to_memory} !== {3'b101, 8'h20, 8'h55}) begin
            n_fail++;
            $display("FAIL write_grant: got %b_%h_%h expected 101_20_55",
                     {m1_gnt, m0_gnt, mem_write}, mem_address, mem_to_memory);
        end
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m1_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_no_rvalid: got %b expected 0", m1_rvalid);
        end
        tick(); tick();
    endtask

    task automatic test_burst();
        logic exp0;
        tick();
        m0_req = 1'b1; m0_addr = 8'hA0; m0_write = 1'b0;
        m1_req = 1'b1; m1_addr = 8'hB0; m1_write = 1'b0;
        tick();
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp0 = ((k / 4) % 2) == 0;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
                n_fail++;
                $display("FAIL burst_cycle%0d: gnt0/gnt1 got %b expected %b",
                         k, {m0_gnt, m1_gnt}, {exp0, ~exp0});
            end
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_tiebreak();
        logic [1:0] exp_g;
`ifdef MEM_ARB_RR_EN
        exp_g = 2'b01;
`else
        exp_g = 2'b10;
`endif
        tick();
        m0_req = 1'b1; m0_addr = 8'h40; m0_write = 1'b0;
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        m0_req = 1'b1; m1_req = 1'b1;
        m1_addr = 8'h41; m1_write = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== exp_g) begin
            n_fail++;
            $display("FAIL tiebreak: gnt0/gnt1 got %b expected %b", {m0_gnt, m1_gnt}, exp_g);
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_saturate();
        tick();
        m1_req = 1'b1; m1_addr = 8'h50; m1_wdata = 8'h77; m1_write = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_gnt, m1_gnt} !== 2'b01) begin
                n_fail++;
                $display("FAIL solo_owner_cycle%0d: got %b expected 01", k, {m0_gnt, m1_gnt});
            end
        end
        m0_req = 1'b1; m0_addr = 8'h51; m0_write = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL saturated_handover: got %b expected 10", {m0_gnt, m1_gnt});
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h55;
        tick();
        m0_req = 1'b1; m0_addr = 8'h30; m0_write = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_gnt: got %b expected 1", m0_gnt);
        end
        tick(); m0_addr = 8'h31;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m0_rvalid, m0_rdata} !== {2'b11, exp_d[0]}) begin
            n_fail++;
            $display("FAIL b2b_0: got %b_%h expected 11_%h", {m0_gnt, m0_rvalid}, m0_rdata, exp_d[0]);
        end
        tick(); m0_addr = 8'h20;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m0_rvalid, m0_rdata} !== {2'b11, exp_d[1]}) begin
            n_fail++;
            $display("FAIL b2b_1: got %b_%h expected 11_%h", {m0_gnt, m0_rvalid}, m0_rdata, exp_d[1]);
        end
        tick(); m0_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, exp_d[2]}) begin
            n_fail++;
            $display("FAIL b2b_2: got %b_%h expected 1_%h", m0_rvalid, m0_rdata, exp_d[2]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m0_rdata} !== {1'b0, exp_d[2]}) begin
            n_fail++;
            $display("FAIL rdata_hold: got %b_%h expected 0_%h", m0_rvalid, m0_rdata, exp_d[2]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        m0_req = 1'b1; m0_addr = 8'h10; m0_write = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_gnt: got %b expected 1", m0_gnt);
        end
        reset = 1'b0;
        m0_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_rvalid, mem_en} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_mid_rvalid%0d: got %b expected 00", k, {m0_rvalid, mem_en});
            end
        end
        n_checks++;
        if (dut.r_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rst_mid_state: got %0d expected %0d", dut.r_state, ST_IDLE);
        end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, mem_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_release: got %b expected 00", {m0_rvalid, mem_en});
        end
    endtask

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00; m0_write = 1'b0;
        m1_req = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00; m1_write = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_burst();
        test_tiebreak();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
